// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the 8N1 UART receiver.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);
    localparam int unsigned STATE_W   = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_WAIT_IDLE = 3'd4;

    // Offset from the start-bit edge to mid-bit, in clocks.
    function automatic int unsigned half_period(input int unsigned div);
        return (div - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized line, samples each bit at
// mid-bit, and presents each correctly framed byte with a one-cycle strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [7:0] out,
    output logic       clk_out
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(half_period(DIV));
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 s;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pend_q, pend_d;
    logic [7:0]           out_q, out_d;
    logic                 clk_out_q, clk_out_d;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (in),
        .q_o (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            pend_q    <= 1'b0;
            out_q     <= 8'h00;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            pend_q    <= pend_d;
            out_q     <= out_d;
            clk_out_q <= clk_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pend_d    = 1'b0;
        out_d     = pend_q ? shift_q : out_q;
        clk_out_d = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_START;
                    cnt_d   = HALF;
                end
            end

            // Start sample lands on the H-th edge after IDLE saw the low level,
            // so all later DIV-spaced samples sit at mid-bit.
            ST_START: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (!s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                        cnt_d   = BIT_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = s;
                    cnt_d          = BIT_LAST;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // Returning to IDLE at mid-stop leaves margin for a back-to-back start.
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (s) begin
                        pend_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_WAIT_IDLE: begin
                if (s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out     = out_q;
    assign clk_out = clk_out_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven with bit-accurate
// timing and a scoreboard predicts each strobe's byte and cycle.
module tb_uart_rx;

    localparam int DIV = 5;
    localparam int H   = (DIV - 1) / 2;
    // Drive edge to visible strobe: 2 sync flops + IDLE detect + 9*DIV+H + output edge.
    localparam int LAT = 4 + 9 * DIV + H;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       line = 1'b1;
    logic [7:0] dout;
    logic       dstrb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    bit rst_at_edge = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         idle_bits;
        logic       exp_pulse;
        logic [7:0] exp_out;
    } vec_t;

    exp_t       q[$];
    logic [7:0] model_out  = 8'h00;
    bit         prev_strb  = 1'b0;

    uart_rx #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (line),
        .out     (dout),
        .clk_out (dstrb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Scoreboard: every cycle either a predicted strobe or a held output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_at_edge) begin
            model_out = 8'h00;
            checks++;
            if (dout !== 8'h00 || dstrb !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: out=%h clk_out=%b, required out=00 clk_out=0", dout, dstrb);
            end
        end else if (dstrb === 1'b1) begin
            pulses++;
            checks++;
            if (prev_strb) begin
                errors++;
                $display("FAIL strobe_width: clk_out high two cycles in a row at cycle %0d", cyc);
            end
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: out=%h at cycle %0d, required no pulse", dout, cyc);
            end else begin
                e = q.pop_front();
                model_out = e.data;
                if (dout !== e.data) begin
                    errors++;
                    $display("FAIL pulse_data: out=%h, required %h", dout, e.data);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse_time: pulse at cycle %0d, required cycle %0d", cyc, e.cyc);
                end
            end
        end else begin
            checks++;
            if (dout !== model_out || dstrb !== 1'b0) begin
                errors++;
                $display("FAIL out_hold: out=%h clk_out=%b at cycle %0d, required out=%h clk_out=0",
                         dout, dstrb, cyc, model_out);
            end
        end
        prev_strb = (dstrb === 1'b1);
    end

    task automatic drive_bit(input logic b);
        line = b;
        repeat (DIV) @(negedge clk);
    endtask

    // Called on a negedge; a good stop bit schedules one predicted strobe.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input int idle_bits, input logic expect_pulse);
        exp_t e;
        if (expect_pulse) begin
            e.data = d;
            e.cyc  = cyc + LAT;
            q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 400 && q.size() != 0; t++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d predicted pulses never seen, required 0", name, q.size());
            q.delete();
        end
        repeat (DIV) @(negedge clk);
    endtask

    task automatic check_pulses(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: %0d pulses, required %0d", name, got, want);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[7];
        int         p0;
        logic [7:0] d;
        logic       ok;

        vecs[0] = '{8'h55, 1'b1, 0, 1'b1, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 2, 1'b1, 8'hA3};
        vecs[2] = '{8'h3C, 1'b0, 2, 1'b0, 8'hA3};
        vecs[3] = '{8'h81, 1'b1, 1, 1'b1, 8'h81};
        vecs[4] = '{8'h00, 1'b1, 0, 1'b1, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1, 1'b1, 8'hFF};
        vecs[6] = '{8'h80, 1'b1, 1, 1'b1, 8'h80};

        rst  = 1'b1;
        line = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 8'h00 || dstrb !== 1'b0) begin
            errors++;
            $display("FAIL init_reset: out=%h clk_out=%b, required 00/0", dout, dstrb);
        end
        rst = 1'b0;
        repeat (2 * DIV) @(negedge clk);

        // Continuous 11-bit pattern: one 0xBB frame every 11*DIV clocks.
        p0 = pulses;
        repeat (6) send_frame(8'hBB, 1'b1, 1, 1'b1);
        drain("continuous");
        check_pulses("continuous_count", pulses - p0, 6);

        // Table: back-to-back, framing error, extremes.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].idle_bits, vecs[i].exp_pulse);
            drain("table");
            checks++;
            if (dout !== vecs[i].exp_out) begin
                errors++;
                $display("FAIL table[%0d]: out=%h, required %h", i, dout, vecs[i].exp_out);
            end
        end

        // Random frames; a bad stop is always followed by idle so WAIT_IDLE releases.
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)), ok);
        end
        drain("random");

        // Start glitch: one clock low must not start a frame.
        p0 = pulses;
        line = 1'b0;
        @(negedge clk);
        line = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        send_frame(8'hF0, 1'b1, 2, 1'b1);
        drain("glitch");
        check_pulses("glitch_count", pulses - p0, 1);

        // Reset during data bit 4 aborts the frame and clears out.
        p0 = pulses;
        d  = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        line = d[4];
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        line = 1'b1;
        @(negedge clk);
        checks++;
        if (dout !== 8'h00 || dstrb !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: out=%h clk_out=%b, required 00/0", dout, dstrb);
        end
        rst = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        send_frame(8'h5A, 1'b1, 2, 1'b1);
        drain("reset_recover");
        check_pulses("reset_count", pulses - p0, 1);

        // Break: 30 bit times low, then a valid frame.
        p0 = pulses;
        line = 1'b0;
        repeat (30 * DIV) @(negedge clk);
        line = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send_frame(8'h11, 1'b1, 2, 1'b1);
        drain("break");
        check_pulses("break_count", pulses - p0, 1);
        checks++;
        if (dout !== 8'h11) begin
            errors++;
            $display("FAIL break_out: out=%h, required 11", dout);
        end

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial (UART, 8N1) receiver for iCE40-class designs.
- Oversamples the serial line with the system clock, using a fixed integer clocks-per-bit divisor.
- Reassembles each frame into a byte and presents it on a parallel output with a one-cycle valid strobe.
- Sits between the external RX pin and the byte-oriented logic downstream.

Parameters:
- DIV, default 16: system clocks per serial bit period. Legal range is DIV >= 4; behaviour for DIV < 4 is undefined.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  serial line, asynchronous to clk. Idle high, LSB first.
- out  output  8  last correctly received byte. Holds its value until the next valid frame.
- clk_out  output  1  one-cycle high strobe when out is updated.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; counters = 0.
  - Synchronizer flops = 1.
  - out = 8'h00; clk_out = 0.
  - Reset mid-frame aborts the frame; no strobe is issued.
- Input synchronizer: 2-flop chain on in, giving 2 cycles of latency. All decisions below use the synchronized signal s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - s==0 moves to START and loads the counter with H = (DIV-1)/2 (integer division).
- START:
  - Count down H cycles, then sample s (mid start bit).
  - s==0: go to DATA, bit index = 0, counter = DIV-1.
  - s==1 (glitch): return to IDLE; nothing else changes.
- DATA:
  - When the counter expires, sample s into shift register bit [index], then reload the counter to DIV-1.
  - Samples fall exactly DIV cycles apart, at mid-bit. LSB first, so the first sampled bit becomes out[0].
  - After index 7, go to STOP.
- STOP:
  - When the counter expires, sample s.
  - s==1: on the next edge out <= shift register and clk_out <= 1 for exactly one cycle; go to IDLE.
  - s==0 (framing error): out unchanged, no strobe; go to WAIT_IDLE.
- WAIT_IDLE: stay until s==1, then go to IDLE. A held-low (break) line therefore never produces frames.
- Timing: the stop sample occurs 9*DIV + H cycles after s first goes low, measured from the cycle IDLE sees s==0. clk_out is asserted on the following edge.
- Back-to-back frames: a start bit that immediately follows a 1-bit stop must be caught. The FSM returns to IDLE at mid-stop, so there are DIV-H cycles of margin.
- clk_out is never high in two consecutive cycles.
- out changes only on the same edge that sets clk_out.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the frame constant DATA_BITS = 8.
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1.
- Counter and shift register stay inline.

Test Plan:
- Continuous frame, DIV=5, one bit every 5 clocks. Repeating 11-bit pattern: start 0; data bits 1,1,0,1,1,1,0,1; stop 1; idle 1. Expected: clk_out pulses once per 55 clocks, out = 8'hBB on every pulse.
- Back-to-back frames 8'h55 then 8'hA3, one stop bit each, no idle gap. Expected: two pulses exactly 50 clocks apart, out = 8'h55 then 8'hA3.
- Framing error: frame for 8'h3C with stop = 0, then line high. Expected: no clk_out pulse, out keeps its previous value. A following valid 8'h81 yields a pulse with out = 8'h81.
- Start glitch: in low for 1 clock, then high. Expected: no pulse, FSM back in IDLE. A subsequent valid 8'hF0 is received correctly.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of a frame. Expected: out = 8'h00 and clk_out = 0 immediately; no pulse for the aborted frame. The next full frame 8'h5A is received.
- Break condition: in held low for 30 bit times, then released and followed by 8'h11. Expected: exactly one pulse, with out = 8'h11.
